// File: rtl/nibble_serial_sub_64_if.sv
// nibble_serial_sub_64_if
//   Bundles the operand and result handshakes of nibble_serial_sub_64.
//   The overflow signal exists only when NSUB_OVERFLOW_EN is defined.
//
//   Signals:
//     in_valid   producer -> block  operand pair on op1/op2 is valid
//     in_ready   block -> producer  block can accept operands
//     op1, op2   producer -> block  64-bit minuend / subtrahend
//     out_valid  block -> consumer  diff/borrow_out hold a finished result
//     out_ready  consumer -> block  consumer takes the result
//     diff       block -> consumer  (op1 - op2) mod 2^64
//     borrow_out block -> consumer  1 iff op1 < op2 (unsigned)
//     overflow   block -> consumer  signed overflow (NSUB_OVERFLOW_EN only)
//
//   Modports: master = producer/consumer side, slave = the subtractor.
interface nibble_serial_sub_64_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] op1;
  logic [63:0] op2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        borrow_out;
`ifdef NSUB_OVERFLOW_EN
  logic        overflow;
`endif

  modport master (
    output in_valid, op1, op2, out_ready,
    input  in_ready, out_valid, diff, borrow_out
`ifdef NSUB_OVERFLOW_EN
    , input overflow
`endif
  );

  modport slave (
    input  in_valid, op1, op2, out_ready,
    output in_ready, out_valid, diff, borrow_out
`ifdef NSUB_OVERFLOW_EN
    , output overflow
`endif
  );
endinterface

// File: rtl/nibble_serial_sub_64.sv
// nibble_serial_sub_64
//   Area-lean 64-bit unsigned subtractor: computes op1 - op2 one nibble per
//   clock with the ripple borrow held in a flop. 16 cycles from accept to
//   result. Results hold in DONE until the consumer takes them.
//
//   Ports:
//     clock  rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    nibble_serial_sub_64_if.slave (operand and result handshakes)
//
//   Optional feature: define NSUB_OVERFLOW_EN to add the signed overflow
//   flag on bus.overflow.
module nibble_serial_sub_64 (
  input logic                        clock,
  input logic                        reset,
  nibble_serial_sub_64_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic [63:0] diff_q, diff_d;
  logic [3:0]  k_q, k_d;
  logic        borrow_q, borrow_d;
  logic        borrow_out_q, borrow_out_d;
`ifdef NSUB_OVERFLOW_EN
  logic        overflow_q, overflow_d;
`endif

  logic [5:0]  nib_base;
  logic [4:0]  nib_res;

  // One 5-bit subtract per cycle on the nibble selected by k; bit 4 is the
  // borrow out of that nibble.
  assign nib_base = {k_q, 2'b00};
  assign nib_res  = {1'b0, a_q[nib_base +: 4]} - {1'b0, b_q[nib_base +: 4]}
                  - {4'b0000, borrow_q};

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    diff_d       = diff_q;
    k_d          = k_q;
    borrow_d     = borrow_q;
    borrow_out_d = borrow_out_q;
`ifdef NSUB_OVERFLOW_EN
    overflow_d   = overflow_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d      = bus.op1;
          b_d      = bus.op2;
          borrow_d = 1'b0;
          k_d      = 4'd0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        diff_d[nib_base +: 4] = nib_res[3:0];
        borrow_d = nib_res[4];
        // k wraps 15 -> 0 on the same edge the operation completes.
        k_d      = k_q + 4'd1;
        if (k_q == 4'd15) begin
          borrow_out_d = nib_res[4];
`ifdef NSUB_OVERFLOW_EN
          // Bit 63 of the result is the top bit of the final nibble.
          overflow_d   = (a_q[63] != b_q[63]) & (nib_res[3] != a_q[63]);
`endif
          state_d      = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      k_q          <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
`ifdef NSUB_OVERFLOW_EN
      overflow_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      diff_q       <= diff_d;
      k_q          <= k_d;
      borrow_q     <= borrow_d;
      borrow_out_q <= borrow_out_d;
`ifdef NSUB_OVERFLOW_EN
      overflow_q   <= overflow_d;
`endif
    end
  end

  // in_ready must drop the moment reset rises, so it is gated by reset
  // directly rather than waiting for the state flop to clear.
  assign bus.in_ready   = (state_q == IDLE) & ~reset;
  assign bus.out_valid  = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
`ifdef NSUB_OVERFLOW_EN
  assign bus.overflow   = overflow_q;
`endif

endmodule

// File: tb/tb_nibble_serial_sub_64.sv
// tb_nibble_serial_sub_64
//   Directed, table-driven bench for nibble_serial_sub_64 plus hand-written
//   sequences for handshake hold-off, backpressure and mid-operation reset.
//   Overflow checks are compiled in when NSUB_OVERFLOW_EN is defined.
module tb_nibble_serial_sub_64;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  nibble_serial_sub_64_if bus ();

  nibble_serial_sub_64 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [63:0] diff;
    logic        borrow;
    logic        ovf;
  } vec_t;

  vec_t vecs [7];

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for in_ready, then present one operand pair for exactly
  // the accept edge; operands are scrambled afterwards.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("in_ready_wait", {63'd0, bus.in_ready}, 64'd1);
    bus.in_valid = 1'b1;
    bus.op1      = a;
    bus.op2      = b;
    tick();
    bus.in_valid = 1'b0;
    bus.op1      = {$urandom, $urandom};
    bus.op2      = {$urandom, $urandom};
  endtask

  // Count cycles after accept until out_valid; 16 expected.
  task automatic waitResult(input string name);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checkOutput({name, "_latency"}, 64'(n), 64'd16);
  endtask

  task automatic checkResult(input string name, input logic [63:0] d,
                             input logic bo, input logic ov);
    checkOutput({name, "_diff"}, bus.diff, d);
    checkOutput({name, "_borrow"}, {63'd0, bus.borrow_out}, {63'd0, bo});
`ifdef NSUB_OVERFLOW_EN
    checkOutput({name, "_ovf"}, {63'd0, bus.overflow}, {63'd0, ov});
`else
    if (ov === 1'bx) $display("[TB] note: unknown overflow expectation");
`endif
  endtask

  task automatic takeResult(input string name);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkOutput({name, "_valid_drop"}, {63'd0, bus.out_valid}, 64'd0);
    checkOutput({name, "_ready_rise"}, {63'd0, bus.in_ready}, 64'd1);
  endtask

  task automatic runVector(input string name, input vec_t v);
    applyStimulus(v.op1, v.op2);
    waitResult(name);
    checkResult(name, v.diff, v.borrow, v.ovf);
    takeResult(name);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op1       = '0;
    bus.op2       = '0;

    vecs[0] = '{64'd5, 64'd3, 64'd2, 1'b0, 1'b0};
    vecs[1] = '{64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[2] = '{64'h0000_0001_0000_0000, 64'd1, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0};
    vecs[3] = '{64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 64'd0, 1'b0, 1'b0};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
    vecs[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h8000_0000_0000_0000, 1'b1, 1'b1};
    vecs[6] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
                64'h0246_8ACF_1357_9BCF, 1'b0, 1'b0};

    // Reset behaviour.
    reset = 1'b1;
    tick();
    tick();
    checkOutput("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    checkOutput("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    checkResult("rst", 64'd0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("rst_release_ready", {63'd0, bus.in_ready}, 64'd1);

    // Table-driven vectors, back to back.
    for (int i = 0; i < 7; i++) begin
      runVector($sformatf("vec%0d", i), vecs[i]);
    end

    // in_valid held with fresh operands during BUSY must not be captured.
    $display("[TB] hold-off and backpressure sequence");
    bus.in_valid = 1'b1;
    bus.op1      = 64'd100;
    bus.op2      = 64'd1;
    tick();
    begin
      int n;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 40) begin
        bus.op1 = {$urandom, $urandom};
        bus.op2 = {$urandom, $urandom};
        if (n == 3 || n == 10)
          checkOutput("busy_in_ready", {63'd0, bus.in_ready}, 64'd0);
        tick();
        n++;
      end
      bus.in_valid = 1'b0;
      checkOutput("hold_latency", 64'(n), 64'd16);
    end
    checkResult("hold", 64'd99, 1'b0, 1'b0);

    // Backpressure: DONE must hold for 5 cycles without out_ready.
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_valid", {63'd0, bus.out_valid}, 64'd1);
      checkOutput("bp_diff", bus.diff, 64'd99);
    end
    takeResult("bp");
    // Immediate next operation after the release.
    runVector("b2b", vecs[6]);

    // Asynchronous reset while k = 8.
    $display("[TB] mid-operation reset sequence");
    applyStimulus(64'h0000_0000_FFFF_FFFF, 64'h0000_0000_1111_1111);
    repeat (8) tick();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_diff", bus.diff, 64'd0);
    checkOutput("midrst_borrow", {63'd0, bus.borrow_out}, 64'd0);
    checkOutput("midrst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    checkOutput("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
`ifdef NSUB_OVERFLOW_EN
    checkOutput("midrst_ovf", {63'd0, bus.overflow}, 64'd0);
`endif
    tick();
    checkOutput("midrst_hold_ready", {63'd0, bus.in_ready}, 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("postrst_ready", {63'd0, bus.in_ready}, 64'd1);
    begin
      vec_t v;
      v = '{64'd10, 64'd4, 64'd6, 1'b0, 1'b0};
      runVector("postrst", v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
